// File: rtl/tmds_period_scheduler_pkg.sv
// TMDS period scheduler shared definitions: control/guard tokens,
// period lengths, FSM state type, delay-line word and ctl_token().
package tmds_period_scheduler_pkg;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;

  localparam logic [9:0] VGB_CH0 = 10'b1011001100;
  localparam logic [9:0] VGB_CH1 = 10'b0100110011;
  localparam logic [9:0] VGB_CH2 = 10'b1011001100;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int DL_DEPTH     = 10;

  typedef enum logic [1:0] {
    ST_CTRL,
    ST_PRE,
    ST_GUARD,
    ST_VIDEO
  } state_t;

  // One delay-line slot: 3 tokens + de/vsync/hsync = 33 bits
  typedef struct packed {
    logic       de;
    logic       vs;
    logic       hs;
    logic [9:0] t2;
    logic [9:0] t1;
    logic [9:0] t0;
  } dl_word_t;

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00: t = CTL00;
      2'b01: t = CTL01;
      2'b10: t = CTL10;
      2'b11: t = CTL11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_delay_line.sv
// Fixed-depth lookahead shift register, zeroed by async reset.
// Ports: clk, rst_n, din[WIDTH], dout[WIDTH] (din delayed DEPTH clocks).
module tmds_delay_line #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tmds_period_scheduler.sv
// TMDS period scheduler: frames video lines with preamble + guard band.
// In: clk, rst_n, de_in, hsync_in, vsync_in, vid0..2_token[10], err_clr.
// Out: chan0..2_token[10], de_out, err_short_blank (sticky).
module tmds_period_scheduler #(
  parameter bit DVI_MODE  = 1'b0,
  parameter int MIN_BLANK = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] vid0_token,
  input  logic [9:0] vid1_token,
  input  logic [9:0] vid2_token,
  input  logic       err_clr,
  output logic [9:0] chan0_token,
  output logic [9:0] chan1_token,
  output logic [9:0] chan2_token,
  output logic       de_out,
  output logic       err_short_blank
);
  import tmds_period_scheduler_pkg::*;

  localparam int CW = $clog2(MIN_BLANK + 1);

  logic [CW-1:0] blank_cnt;
  logic          de_prev;
  logic          line_act;
  logic          rise;
  logic          blank_ok;
  logic          frame;
  logic          short_err;
  logic          de_gate;
  state_t        state_q;
  state_t        state_d;
  logic [2:0]    phase_q;
  logic [2:0]    phase_d;
  dl_word_t      dl_in;
  dl_word_t      dl_out;
  logic [9:0]    ch0_d;
  logic [9:0]    ch1_d;
  logic [9:0]    ch2_d;
  logic          de_d;

  assign rise     = de_in & ~de_prev;
  assign blank_ok = (blank_cnt >= CW'(MIN_BLANK));
  assign frame    = rise & !DVI_MODE & blank_ok
                  & (state_q == ST_CTRL);
  assign short_err = rise & !DVI_MODE
                   & ~(blank_ok & (state_q == ST_CTRL));

  // de only enters the pipe for lines that began with a seen rise,
  // so a line already high when reset releases is dropped whole.
  assign de_gate = de_in & (rise | line_act);

  always_comb begin
    dl_in    = '0;
    dl_in.de = de_gate;
    dl_in.vs = vsync_in;
    dl_in.hs = hsync_in;
    dl_in.t2 = vid2_token;
    dl_in.t1 = vid1_token;
    dl_in.t0 = vid0_token;
  end

  tmds_delay_line #(
    .WIDTH($bits(dl_word_t)),
    .DEPTH(DL_DEPTH)
  ) u_dl (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dl_in),
    .dout (dl_out)
  );

  // de_prev resets high: a held-high de after reset is not a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev   <= 1'b1;
      line_act  <= 1'b0;
      blank_cnt <= '0;
    end else begin
      de_prev  <= de_in;
      line_act <= de_gate;
      if (de_in)
        blank_cnt <= '0;
      else if (!blank_ok)
        blank_cnt <= blank_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_short_blank <= 1'b0;
    else if (short_err)
      err_short_blank <= 1'b1;
    else if (err_clr)
      err_short_blank <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CTRL;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // state_d names the period of the token being registered now
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    unique case (state_q)
      ST_CTRL: begin
        if (frame)
          state_d = ST_PRE;
        else if (dl_out.de)
          state_d = ST_VIDEO;
      end
      ST_PRE: begin
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'(PREAMBLE_LEN - 1)) begin
          state_d = ST_GUARD;
          phase_d = '0;
        end
      end
      ST_GUARD: begin
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'(GUARD_LEN - 1)) begin
          state_d = dl_out.de ? ST_VIDEO : ST_CTRL;
          phase_d = '0;
        end
      end
      ST_VIDEO: begin
        if (!dl_out.de)
          state_d = ST_CTRL;
      end
      default: state_d = ST_CTRL;
    endcase
  end

  always_comb begin
    ch0_d = ctl_token({dl_out.vs, dl_out.hs});
    ch1_d = CTL00;
    ch2_d = CTL00;
    de_d  = 1'b0;
    unique case (state_d)
      ST_PRE: begin
        ch1_d = CTL01;
      end
      ST_GUARD: begin
        ch0_d = VGB_CH0;
        ch1_d = VGB_CH1;
        ch2_d = VGB_CH2;
      end
      ST_VIDEO: begin
        ch0_d = dl_out.t0;
        ch1_d = dl_out.t1;
        ch2_d = dl_out.t2;
        de_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan0_token <= CTL00;
      chan1_token <= CTL00;
      chan2_token <= CTL00;
      de_out      <= 1'b0;
    end else begin
      chan0_token <= ch0_d;
      chan1_token <= ch1_d;
      chan2_token <= ch2_d;
      de_out      <= de_d;
    end
  end

endmodule
